// File: rtl/fifo_thresh.sv
// Synchronous first-word-fall-through FIFO with registered occupancy flags,
// programmable almost-full/almost-empty thresholds and sticky error flags.
module fifo_thresh #(
   parameter int DATA_WIDTH   = 16,
   parameter int DEPTH        = 8,
   parameter int AFULL_LEVEL  = DEPTH - 2,
   parameter int AEMPTY_LEVEL = 1
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic [DATA_WIDTH-1:0]    i_w_data,
   input  logic                     i_w_data_stb,
   input  logic                     i_r_data_stb,
   input  logic                     i_flush,
   input  logic                     i_clear_err,
   output logic [DATA_WIDTH-1:0]    o_r_data,
   output logic                     o_full,
   output logic                     o_empty,
   output logic                     o_almost_full,
   output logic                     o_almost_empty,
   output logic [$clog2(DEPTH):0]   o_item_count,
   output logic [$clog2(DEPTH):0]   o_free_size,
   output logic                     o_overflow,
   output logic                     o_underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_LEVEL);
   localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_LEVEL);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  full_q, full_d;
   logic                  empty_q, empty_d;
   logic                  afull_q, afull_d;
   logic                  aempty_q, aempty_d;
   logic                  overflow_q, overflow_d;
   logic                  underflow_q, underflow_d;
   logic                  rd_ok;
   logic                  wr_ok;

   always_comb begin
      rd_ok       = i_r_data_stb && !empty_q;
      // A full FIFO can still take a write when a read frees a slot this cycle
      wr_ok       = i_w_data_stb && (!full_q || rd_ok);
      mem_d       = mem_q;
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      count_d     = count_q;
      overflow_d  = overflow_q && !i_clear_err;
      underflow_d = underflow_q && !i_clear_err;
      if (i_flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (wr_ok) begin
            mem_d[wr_ptr_q] = i_w_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
         end
         if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
         if (i_w_data_stb && !wr_ok) begin
            overflow_d = 1'b1;
         end
         if (i_r_data_stb && empty_q) begin
            underflow_d = 1'b1;
         end
      end
      // Flags come from the next count so they change together with it
      full_d   = (count_d == DEPTH_C);
      empty_d  = (count_d == '0);
      afull_d  = (count_d >= AFULL_C);
      aempty_d = (count_d <= AEMPTY_C);
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         count_q     <= '0;
         full_q      <= 1'b0;
         empty_q     <= 1'b1;
         afull_q     <= (AFULL_C == '0);
         aempty_q    <= 1'b1;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         count_q     <= count_d;
         full_q      <= full_d;
         empty_q     <= empty_d;
         afull_q     <= afull_d;
         aempty_q    <= aempty_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage carries no reset; stale words are unreachable once pointers clear
   always_ff @(posedge i_clk) begin
      mem_q <= mem_d;
   end

   assign o_r_data       = mem_q[rd_ptr_q];
   assign o_full         = full_q;
   assign o_empty        = empty_q;
   assign o_almost_full  = afull_q;
   assign o_almost_empty = aempty_q;
   assign o_item_count   = count_q;
   assign o_free_size    = DEPTH_C - count_q;
   assign o_overflow     = overflow_q;
   assign o_underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_thresh.sv
// Scoreboard bench for fifo_thresh: directed scenarios followed by random
// traffic, compared against a queue-based model of the FIFO behaviour.
module tb_fifo_thresh;

   localparam int DW     = 16;
   localparam int DEPTH  = 8;
   localparam int AFULL  = 6;
   localparam int AEMPTY = 1;

   logic          clk;
   logic          i_reset;
   logic [DW-1:0] i_w_data;
   logic          i_w_data_stb;
   logic          i_r_data_stb;
   logic          i_flush;
   logic          i_clear_err;
   logic [DW-1:0] o_r_data;
   logic          o_full;
   logic          o_empty;
   logic          o_almost_full;
   logic          o_almost_empty;
   logic [3:0]    o_item_count;
   logic [3:0]    o_free_size;
   logic          o_overflow;
   logic          o_underflow;

   int num_checks = 0;
   int num_errors = 0;

   logic [DW-1:0] sb_q[$];
   int            m_count = 0;
   logic          m_ovf   = 1'b0;
   logic          m_unf   = 1'b0;

   fifo_thresh #(
      .DATA_WIDTH  (DW),
      .DEPTH       (DEPTH),
      .AFULL_LEVEL (AFULL),
      .AEMPTY_LEVEL(AEMPTY)
   ) dut (
      .i_clk         (clk),
      .i_reset       (i_reset),
      .i_w_data      (i_w_data),
      .i_w_data_stb  (i_w_data_stb),
      .i_r_data_stb  (i_r_data_stb),
      .i_flush       (i_flush),
      .i_clear_err   (i_clear_err),
      .o_r_data      (o_r_data),
      .o_full        (o_full),
      .o_empty       (o_empty),
      .o_almost_full (o_almost_full),
      .o_almost_empty(o_almost_empty),
      .o_item_count  (o_item_count),
      .o_free_size   (o_free_size),
      .o_overflow    (o_overflow),
      .o_underflow   (o_underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkVal(input string name, input int actual, input int expected);
      num_checks++;
      if (actual != expected) begin
         num_errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // The monitor sees every accepted read half a cycle before it commits
   always @(negedge clk) begin
      if (!i_reset && !i_flush && i_r_data_stb && !o_empty) begin
         if (sb_q.size() == 0) begin
            checkVal("read_with_model_empty", 1, 0);
         end else begin
            checkVal("read_data", int'(o_r_data), int'(sb_q[0]));
            void'(sb_q.pop_front());
         end
      end
   end

   task automatic checkOutput();
      checkVal("item_count", int'(o_item_count), m_count);
      checkVal("free_size", int'(o_free_size), DEPTH - m_count);
      checkVal("full", int'(o_full), int'(m_count == DEPTH));
      checkVal("empty", int'(o_empty), int'(m_count == 0));
      checkVal("almost_full", int'(o_almost_full), int'(m_count >= AFULL));
      checkVal("almost_empty", int'(o_almost_empty), int'(m_count <= AEMPTY));
      checkVal("overflow", int'(o_overflow), int'(m_ovf));
      checkVal("underflow", int'(o_underflow), int'(m_unf));
      if (m_count > 0 && sb_q.size() > 0) begin
         checkVal("head_data", int'(o_r_data), int'(sb_q[0]));
      end
   endtask

   task automatic applyStimulus(input logic w, input logic [DW-1:0] d, input logic r,
                                input logic fl, input logic ce, input logic rs);
      logic rd_acc;
      logic wr_acc;
      i_w_data_stb = w;
      i_w_data     = d;
      i_r_data_stb = r;
      i_flush      = fl;
      i_clear_err  = ce;
      i_reset      = rs;
      @(posedge clk);
      if (rs) begin
         sb_q.delete();
         m_count = 0;
         m_ovf   = 1'b0;
         m_unf   = 1'b0;
      end else begin
         if (ce) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
         end
         if (fl) begin
            sb_q.delete();
            m_count = 0;
         end else begin
            rd_acc = r && (m_count > 0);
            wr_acc = w && ((m_count < DEPTH) || rd_acc);
            if (r && m_count == 0) m_unf = 1'b1;
            if (w && !wr_acc) m_ovf = 1'b1;
            if (rd_acc) m_count--;
            if (wr_acc) begin
               sb_q.push_back(d);
               m_count++;
            end
         end
      end
      #1;
      checkOutput();
   endtask

   task automatic idle();
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      i_reset = 1'b1; i_w_data = '0; i_w_data_stb = 1'b0;
      i_r_data_stb = 1'b0; i_flush = 1'b0; i_clear_err = 1'b0;

      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
      checkVal("reset_free_size", int'(o_free_size), 8);

      $display("[TB] fill to full and overflow");
      for (int k = 1; k <= 8; k++) begin
         applyStimulus(1'b1, DW'(16'h0011 * k), 1'b0, 1'b0, 1'b0, 1'b0);
         checkVal("fill_almost_full", int'(o_almost_full), int'(k >= 6));
      end
      checkVal("fill_count", int'(o_item_count), 8);
      applyStimulus(1'b1, 16'h0099, 1'b0, 1'b0, 1'b0, 1'b0);
      checkVal("overflow_set", int'(o_overflow), 1);
      checkVal("overflow_count", int'(o_item_count), 8);

      $display("[TB] drain and underflow");
      for (int k = 1; k <= 8; k++) begin
         checkVal("drain_order", int'(o_r_data), 16'h0011 * k);
         applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      end
      checkVal("drain_empty", int'(o_empty), 1);
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      checkVal("underflow_set", int'(o_underflow), 1);

      $display("[TB] simultaneous read/write while full");
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int k = 0; k < 8; k++)
         applyStimulus(1'b1, DW'(16'h0101 * k), 1'b0, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 16; k++)
         applyStimulus(1'b1, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b0);
      checkVal("rw_full_overflow", int'(o_overflow), 0);
      for (int k = 0; k < 8; k++)
         applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);

      $display("[TB] read+write while empty");
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b1, 16'hBEEF, 1'b1, 1'b0, 1'b0, 1'b0);
      checkVal("beef_underflow", int'(o_underflow), 1);
      checkVal("beef_data", int'(o_r_data), 16'hBEEF);
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);

      $display("[TB] flush then clear errors");
      for (int k = 0; k < 5; k++)
         applyStimulus(1'b1, DW'(16'h0A00 + k), 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 16'h5555, 1'b1, 1'b1, 1'b0, 1'b0);
      checkVal("flush_count", int'(o_item_count), 0);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
      checkVal("clear_underflow", int'(o_underflow), 0);

      $display("[TB] reset mid-operation");
      for (int k = 0; k < 4; k++)
         applyStimulus(1'b1, DW'(16'h0C00 + k), 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 16'h7777, 1'b0, 1'b0, 1'b0, 1'b1);
      checkVal("reset_empty", int'(o_empty), 1);

      $display("[TB] random traffic");
      for (int k = 0; k < 800; k++) begin
         applyStimulus(($urandom % 100) < 55, DW'($urandom), ($urandom % 100) < 50,
                       ($urandom % 100) < 2, ($urandom % 100) < 5, ($urandom % 200) < 1);
      end
      idle();

      $display("Result: errors=%0d of %0d checks", num_errors, num_checks);
      $finish;
   end

endmodule
